// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the successive-approximation
// search controller.
//   sar_state_t   : controller FSM states (IDLE, CMP, DONE, ERR)
//   SAR_DEF_WIDTH : default operand width, matches the 4-bit comparator
package sar_pkg;

  localparam int SAR_DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_search_if.sv
// sar_search_if: bundles the start/done handshake and the comparator-side
// signals of the SAR controller.
//   start            : request a new search
//   equal/greater/lower : comparator flags (a vs trial)
//   trial            : value driven onto the comparator b input
//   busy, done       : search in progress / single-cycle completion pulse
//   result, error    : searched value and non-one-hot flag indication
//   steps            : CMP cycles used (only with SAR_STEP_COUNT_EN)
// Modports: slave = the SAR controller, master = the surrounding logic.
// Optional feature macro: SAR_STEP_COUNT_EN.
interface sar_search_if #(
  parameter int WIDTH = sar_pkg::SAR_DEF_WIDTH
);

  localparam int SW = $clog2(WIDTH + 1);

  logic             start;
  logic             equal;
  logic             greater;
  logic             lower;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;
`ifdef SAR_STEP_COUNT_EN
  logic [SW-1:0]    steps;
`endif

  modport slave (
    input  start, equal, greater, lower,
`ifdef SAR_STEP_COUNT_EN
    output steps,
`endif
    output trial, busy, done, result, error
  );

  modport master (
    output start, equal, greater, lower,
`ifdef SAR_STEP_COUNT_EN
    input  steps,
`endif
    input  trial, busy, done, result, error
  );

endinterface

// File: rtl/sar_flag_check.sv
// sar_flag_check: combinational validity check of the comparator flags.
//   equal_i, greater_i, lower_i : comparator flags
//   flags_ok_o                  : exactly one flag is set
module sar_flag_check (
  input  logic equal_i,
  input  logic greater_i,
  input  logic lower_i,
  output logic flags_ok_o
);

  // Odd parity means one or three flags set; excluding all-three leaves one-hot.
  assign flags_ok_o = (equal_i ^ greater_i ^ lower_i) & ~(equal_i & greater_i & lower_i);

endmodule

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller driving the b input of a
// magnitude comparator and binary-searching the unknown a operand.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sar_search_if.slave (start, flags in; trial, busy, done,
//                result, error [, steps] out)
// Optional feature macro: SAR_STEP_COUNT_EN adds the steps counter/output.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  sar_search_if.slave   bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic [KW-1:0]    k_q, k_d;
  logic             flags_ok;

`ifdef SAR_STEP_COUNT_EN
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  logic [SW-1:0]    steps_q, steps_d;
`endif

  sar_flag_check u_flag_check (
    .equal_i    (bus.equal),
    .greater_i  (bus.greater),
    .lower_i    (bus.lower),
    .flags_ok_o (flags_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      k_q      <= '0;
`ifdef SAR_STEP_COUNT_EN
      steps_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      error_q  <= error_d;
      k_q      <= k_d;
`ifdef SAR_STEP_COUNT_EN
      steps_q  <= steps_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    error_d  = error_q;
    k_d      = k_q;
`ifdef SAR_STEP_COUNT_EN
    steps_d  = steps_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          trial_d             = '0;
          trial_d[WIDTH-1]    = 1'b1;
          k_d                 = K_TOP;
          result_d            = '0;
          error_d             = 1'b0;
`ifdef SAR_STEP_COUNT_EN
          steps_d             = '0;
`endif
          state_d             = CMP;
        end
      end
      CMP: begin
`ifdef SAR_STEP_COUNT_EN
        steps_d = steps_q + S_ONE;
`endif
        if (!flags_ok) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = ERR;
        end else if (bus.equal) begin
          result_d = trial_q;
          state_d  = DONE;
        end else begin
          // Bit k survives only when a is above the trial.
          trial_d[k_q] = bus.greater;
          if (k_q != '0) begin
            trial_d[k_q - K_ONE] = 1'b1;
            k_d                  = k_q - K_ONE;
          end else begin
            result_d = trial_d;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE) || (state_q == ERR);
  assign bus.result = result_q;
  assign bus.error  = error_q;
`ifdef SAR_STEP_COUNT_EN
  assign bus.steps  = steps_q;
`endif

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_val;
  logic       force_en;
  int         checks;
  int         failures;

  sar_search_if #(.WIDTH(4)) bus ();

  // Comparator model with a = secret value; force_en blanks all flags.
  assign bus.equal   = force_en ? 1'b0 : (a_val == bus.trial);
  assign bus.greater = force_en ? 1'b0 : (a_val >  bus.trial);
  assign bus.lower   = force_en ? 1'b0 : (a_val <  bus.trial);

  sar_search #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]      a;
    logic [3:0][3:0] seq;   // seq[0] is the first trial
    int              ncmp;
    logic [3:0]      res;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", nm, act, exp);
    end
  endtask

  // Runs one search; err_at > 0 blanks the flags at that comparison,
  // pulse_start raises start during the second CMP cycle.
  task automatic run(input string nm, input logic [3:0] av, input logic [3:0][3:0] seq,
                     input int ncmp, input logic [3:0] res, input logic err,
                     input int err_at, input bit pulse_start);
    int cnt;
    bit seen;
    a_val = av;
    @(negedge clk);
    chk({nm, " idle_done"}, {31'd0, bus.done}, 32'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cnt  = 0;
    seen = 0;
    while (cnt < 12 && !seen) begin
      cnt++;
      force_en  = (cnt == err_at);
      bus.start = pulse_start && (cnt == 2);
      #1;
      if (bus.done) begin
        seen = 1;
      end else begin
        chk($sformatf("%s busy_c%0d", nm, cnt), {31'd0, bus.busy}, 32'd1);
        if (cnt <= 4)
          chk($sformatf("%s trial_c%0d", nm, cnt), {28'd0, bus.trial}, {28'd0, seq[cnt-1]});
        @(posedge clk);
        #1;
      end
    end
    force_en  = 1'b0;
    bus.start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s done_timeout act=none req=done", nm);
    end else begin
      chk({nm, " latency"}, cnt, ncmp + 1);
      chk({nm, " result"}, {28'd0, bus.result}, {28'd0, res});
      chk({nm, " error"}, {31'd0, bus.error}, {31'd0, err});
      chk({nm, " busy_at_done"}, {31'd0, bus.busy}, 32'd1);
`ifdef SAR_STEP_COUNT_EN
      chk({nm, " steps"}, {29'd0, bus.steps}, ncmp);
`endif
      @(posedge clk);
      #1;
      chk({nm, " busy_after"}, {31'd0, bus.busy}, 32'd0);
      chk({nm, " done_after"}, {31'd0, bus.done}, 32'd0);
      chk({nm, " result_held"}, {28'd0, bus.result}, {28'd0, res});
      chk({nm, " error_held"}, {31'd0, bus.error}, {31'd0, err});
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    force_en  = 1'b0;
    a_val     = 4'd0;

    tbl[0] = '{4'd10, {4'd0,  4'd10, 4'd12, 4'd8}, 3, 4'd10};
    tbl[1] = '{4'd0,  {4'd1,  4'd2,  4'd4,  4'd8}, 4, 4'd0};
    tbl[2] = '{4'd15, {4'd15, 4'd14, 4'd12, 4'd8}, 4, 4'd15};
    tbl[3] = '{4'd8,  {4'd0,  4'd0,  4'd0,  4'd8}, 1, 4'd8};
    tbl[4] = '{4'd5,  {4'd5,  4'd6,  4'd4,  4'd8}, 4, 4'd5};
    tbl[5] = '{4'd7,  {4'd7,  4'd6,  4'd4,  4'd8}, 4, 4'd7};
    tbl[6] = '{4'd1,  {4'd1,  4'd2,  4'd4,  4'd8}, 4, 4'd1};
    tbl[7] = '{4'd12, {4'd0,  4'd0,  4'd12, 4'd8}, 2, 4'd12};
    tbl[8] = '{4'd9,  {4'd9,  4'd10, 4'd12, 4'd8}, 4, 4'd9};
    tbl[9] = '{4'd14, {4'd0,  4'd14, 4'd12, 4'd8}, 3, 4'd14};

    repeat (2) @(posedge clk);
    #1;
    chk("rst trial",  {28'd0, bus.trial},  32'd0);
    chk("rst busy",   {31'd0, bus.busy},   32'd0);
    chk("rst done",   {31'd0, bus.done},   32'd0);
    chk("rst result", {28'd0, bus.result}, 32'd0);
    chk("rst error",  {31'd0, bus.error},  32'd0);
`ifdef SAR_STEP_COUNT_EN
    chk("rst steps",  {29'd0, bus.steps},  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d_a%0d", i, tbl[i].a), tbl[i].a, tbl[i].seq,
          tbl[i].ncmp, tbl[i].res, 1'b0, 0, 1'b0);

    // Flags blanked at the second comparison (trial 12 for a=10).
    run("err_flags", 4'd10, {4'd0, 4'd0, 4'd12, 4'd8}, 2, 4'd0, 1'b1, 2, 1'b0);
    // Recovery: error cleared by the next accepted start.
    run("post_err", 4'd3, {4'd3, 4'd2, 4'd4, 4'd8}, 4, 4'd3, 1'b0, 0, 1'b0);
    // Start pulsed mid-search must not disturb the trial sequence.
    run("start_in_cmp", 4'd9, {4'd9, 4'd10, 4'd12, 4'd8}, 4, 4'd9, 1'b0, 0, 1'b1);

    // Reset asserted mid-search aborts at once with no done.
    a_val = 4'd10;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_abort trial", {28'd0, bus.trial}, 32'd12);
    rst_n = 1'b0;
    #1;
    chk("abort trial",  {28'd0, bus.trial},  32'd0);
    chk("abort busy",   {31'd0, bus.busy},   32'd0);
    chk("abort done",   {31'd0, bus.done},   32'd0);
    chk("abort result", {28'd0, bus.result}, 32'd0);
    chk("abort error",  {31'd0, bus.error},  32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort done_c%0d", c), {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset_a5", 4'd5, {4'd5, 4'd6, 4'd4, 4'd8}, 4, 4'd5, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
